// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: central stall/flush sequencer for the 5-stage core.
// Resolves load-use hazards, taken-branch flushes and I/D-cache miss freezes.
// Optional performance counters are built when HAZARD_PERF_COUNTERS_EN is defined.
module pipeline_hazard_controller #(
  parameter int unsigned REG_ADD_WIDTH    = 5,
  parameter int unsigned D_CACHE_LW_WIDTH = 3,
  parameter int unsigned FLUSH_CYCLES     = 1
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [REG_ADD_WIDTH-1:0]    ID_RS1_ADDRESS,
  input  logic [REG_ADD_WIDTH-1:0]    ID_RS2_ADDRESS,
  input  logic                        ID_RS1_USED,
  input  logic                        ID_RS2_USED,
  input  logic [REG_ADD_WIDTH-1:0]    EX_RD_ADDRESS,
  input  logic                        EX_RD_WRITE_ENABLE,
  input  logic [D_CACHE_LW_WIDTH-1:0] EX_DATA_CACHE_LOAD,
  input  logic                        BRANCH_TAKEN,
  input  logic                        I_CACHE_READY,
  input  logic                        D_CACHE_READY,
  output logic                        STALL_PROGRAM_COUNTER,
  output logic                        STALL_INSTRUCTION_FETCH,
  output logic                        STALL_DECODE,
  output logic                        STALL_EXECUTION_STAGE,
  output logic                        STALL_MEMORY,
  output logic                        FLUSH_FETCH,
  output logic                        FLUSH_DECODE,
  output logic [1:0]                  CONTROLLER_STATE
`ifdef HAZARD_PERF_COUNTERS_EN
  ,
  output logic [31:0]                 PERF_LOAD_USE_COUNT,
  output logic [31:0]                 PERF_BRANCH_FLUSH_COUNT,
  output logic [31:0]                 PERF_DMISS_CYCLE_COUNT
`endif
);

  typedef enum logic [1:0] {
    S_RUN          = 2'd0,
    S_LOAD_BUBBLE  = 2'd1,
    S_BRANCH_FLUSH = 2'd2,
    S_DMISS        = 2'd3
  } state_t;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

  state_t     state;
  state_t     state_nxt;
  state_t     eff_state;
  logic [2:0] flush_cnt;
  logic [2:0] flush_cnt_nxt;
  logic       load_use;

  // Load-use hazard: a load in EX writes a register that decode reads (x0 excluded).
  always_comb begin
    load_use = (|EX_DATA_CACHE_LOAD) && EX_RD_WRITE_ENABLE && (|EX_RD_ADDRESS) &&
               ((ID_RS1_USED && (ID_RS1_ADDRESS == EX_RD_ADDRESS)) ||
                (ID_RS2_USED && (ID_RS2_ADDRESS == EX_RD_ADDRESS)));
  end

  // DMISS remembers no pending state explicitly: the frozen flush count decides
  // whether the pipeline resumes in BRANCH_FLUSH or RUN once the data cache is ready.
  always_comb begin
    eff_state = state;
    if (state == S_DMISS) begin
      eff_state = (flush_cnt != 3'd0) ? S_BRANCH_FLUSH : S_RUN;
    end
  end

  // Prioritised stall/flush decode and next-state selection.
  always_comb begin
    STALL_PROGRAM_COUNTER   = 1'b0;
    STALL_INSTRUCTION_FETCH = 1'b0;
    STALL_DECODE            = 1'b0;
    STALL_EXECUTION_STAGE   = 1'b0;
    STALL_MEMORY            = 1'b0;
    FLUSH_FETCH             = 1'b0;
    FLUSH_DECODE            = 1'b0;
    state_nxt               = S_RUN;
    flush_cnt_nxt           = flush_cnt;
    if (RST) begin
      FLUSH_FETCH   = 1'b1;
      FLUSH_DECODE  = 1'b1;
      flush_cnt_nxt = '0;
    end else if (!D_CACHE_READY) begin
      STALL_PROGRAM_COUNTER   = 1'b1;
      STALL_INSTRUCTION_FETCH = 1'b1;
      STALL_DECODE            = 1'b1;
      STALL_EXECUTION_STAGE   = 1'b1;
      STALL_MEMORY            = 1'b1;
      state_nxt               = S_DMISS;
    end else if (BRANCH_TAKEN) begin
      FLUSH_FETCH   = 1'b1;
      FLUSH_DECODE  = 1'b1;
      flush_cnt_nxt = FLUSH_INIT;
      state_nxt     = (FLUSH_CYCLES != 0) ? S_BRANCH_FLUSH : S_RUN;
    end else if (eff_state == S_BRANCH_FLUSH) begin
      FLUSH_FETCH   = 1'b1;
      flush_cnt_nxt = flush_cnt - 3'd1;
      state_nxt     = (flush_cnt == 3'd1) ? S_RUN : S_BRANCH_FLUSH;
    end else if (load_use && (eff_state != S_LOAD_BUBBLE)) begin
      STALL_PROGRAM_COUNTER   = 1'b1;
      STALL_INSTRUCTION_FETCH = 1'b1;
      FLUSH_DECODE            = 1'b1;
      state_nxt               = S_LOAD_BUBBLE;
    end else if (!I_CACHE_READY) begin
      STALL_PROGRAM_COUNTER = 1'b1;
      FLUSH_FETCH           = 1'b1;
    end
  end

  // State register and flush counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_RUN;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  assign CONTROLLER_STATE = state;

`ifdef HAZARD_PERF_COUNTERS_EN
  // Saturating event counters; observation only, no feedback into control.
  always_ff @(posedge CLK) begin
    if (RST) begin
      PERF_LOAD_USE_COUNT     <= '0;
      PERF_BRANCH_FLUSH_COUNT <= '0;
      PERF_DMISS_CYCLE_COUNT  <= '0;
    end else begin
      if ((state_nxt == S_LOAD_BUBBLE) && (PERF_LOAD_USE_COUNT != '1))
        PERF_LOAD_USE_COUNT <= PERF_LOAD_USE_COUNT + 32'd1;
      if (BRANCH_TAKEN && D_CACHE_READY && (PERF_BRANCH_FLUSH_COUNT != '1))
        PERF_BRANCH_FLUSH_COUNT <= PERF_BRANCH_FLUSH_COUNT + 32'd1;
      if (!D_CACHE_READY && (PERF_DMISS_CYCLE_COUNT != '1))
        PERF_DMISS_CYCLE_COUNT <= PERF_DMISS_CYCLE_COUNT + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: directed vector table on two instances
// (FLUSH_CYCLES=2 and FLUSH_CYCLES=0) followed by random stimulus against a
// behavioural model. Perf counters are checked when HAZARD_PERF_COUNTERS_EN is defined.
module tb_pipeline_hazard_controller;

  logic       CLK;
  logic       RST;
  logic [4:0] rs1, rs2, rd;
  logic       u1, u2, we, bt, icr, dcr;
  logic [2:0] ld;

  logic [6:0] out_a, out_b;
  logic [1:0] st_a, st_b;
`ifdef HAZARD_PERF_COUNTERS_EN
  logic [31:0] plu_a, pbr_a, pdm_a, plu_b, pbr_b, pdm_b;
`endif

  int errors = 0;
  int checks = 0;

  pipeline_hazard_controller #(.REG_ADD_WIDTH(5), .D_CACHE_LW_WIDTH(3), .FLUSH_CYCLES(2)) dut_a (
    .CLK(CLK), .RST(RST),
    .ID_RS1_ADDRESS(rs1), .ID_RS2_ADDRESS(rs2), .ID_RS1_USED(u1), .ID_RS2_USED(u2),
    .EX_RD_ADDRESS(rd), .EX_RD_WRITE_ENABLE(we), .EX_DATA_CACHE_LOAD(ld),
    .BRANCH_TAKEN(bt), .I_CACHE_READY(icr), .D_CACHE_READY(dcr),
    .STALL_PROGRAM_COUNTER(out_a[6]), .STALL_INSTRUCTION_FETCH(out_a[5]),
    .STALL_DECODE(out_a[4]), .STALL_EXECUTION_STAGE(out_a[3]), .STALL_MEMORY(out_a[2]),
    .FLUSH_FETCH(out_a[1]), .FLUSH_DECODE(out_a[0]), .CONTROLLER_STATE(st_a)
`ifdef HAZARD_PERF_COUNTERS_EN
    , .PERF_LOAD_USE_COUNT(plu_a), .PERF_BRANCH_FLUSH_COUNT(pbr_a), .PERF_DMISS_CYCLE_COUNT(pdm_a)
`endif
  );

  pipeline_hazard_controller #(.REG_ADD_WIDTH(5), .D_CACHE_LW_WIDTH(3), .FLUSH_CYCLES(0)) dut_b (
    .CLK(CLK), .RST(RST),
    .ID_RS1_ADDRESS(rs1), .ID_RS2_ADDRESS(rs2), .ID_RS1_USED(u1), .ID_RS2_USED(u2),
    .EX_RD_ADDRESS(rd), .EX_RD_WRITE_ENABLE(we), .EX_DATA_CACHE_LOAD(ld),
    .BRANCH_TAKEN(bt), .I_CACHE_READY(icr), .D_CACHE_READY(dcr),
    .STALL_PROGRAM_COUNTER(out_b[6]), .STALL_INSTRUCTION_FETCH(out_b[5]),
    .STALL_DECODE(out_b[4]), .STALL_EXECUTION_STAGE(out_b[3]), .STALL_MEMORY(out_b[2]),
    .FLUSH_FETCH(out_b[1]), .FLUSH_DECODE(out_b[0]), .CONTROLLER_STATE(st_b)
`ifdef HAZARD_PERF_COUNTERS_EN
    , .PERF_LOAD_USE_COUNT(plu_b), .PERF_BRANCH_FLUSH_COUNT(pbr_b), .PERF_DMISS_CYCLE_COUNT(pdm_b)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Output bit order: {STALL_PC, STALL_IF, STALL_DEC, STALL_EX, STALL_MEM, FLUSH_FETCH, FLUSH_DECODE}
  typedef struct {
    logic       rst;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       we;
    logic [2:0] ld;
    logic       bt, icr, dcr;
    logic [6:0] ea;
    logic [1:0] sa;
    logic [6:0] eb;
    logic [1:0] sb;
    logic       chk_st;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model state per instance: remaining flush cycles, bubble just issued,
  // data miss in progress, and event counts.
  int m_rem[2], m_bub[2], m_miss[2], m_lu[2], m_br[2], m_dm[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                        input logic e1, input logic e2, input logic [4:0] d, input logic w,
                        input logic [2:0] l, input logic b, input logic ic, input logic dc);
    RST = r; rs1 = a1; rs2 = a2; u1 = e1; u2 = e2; rd = d; we = w; ld = l;
    bt = b; icr = ic; dcr = dc;
  endtask

  task automatic add(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                     input logic e1, input logic e2, input logic [4:0] d, input logic w,
                     input logic [2:0] l, input logic b, input logic ic, input logic dc,
                     input logic [6:0] ea, input logic [1:0] sa,
                     input logic [6:0] eb, input logic [1:0] sb, input logic c);
    vec_t v;
    v.rst = r; v.rs1 = a1; v.rs2 = a2; v.u1 = e1; v.u2 = e2; v.rd = d; v.we = w; v.ld = l;
    v.bt = b; v.icr = ic; v.dcr = dc; v.ea = ea; v.sa = sa; v.eb = eb; v.sb = sb; v.chk_st = c;
    tbl.push_back(v);
  endtask

  task automatic add_idle(input logic [6:0] ea, input logic [1:0] sa,
                          input logic [6:0] eb, input logic [1:0] sb);
    add(0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 1, 1, ea, sa, eb, sb, 1);
  endtask

  task automatic tick();
    @(negedge CLK);
    @(posedge CLK);
    #1;
  endtask

  task automatic model_step(input int idx, input int fc, output logic [6:0] eo, output logic [1:0] es);
    bit hz;
    hz = (ld != 0) && we && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    es = (m_miss[idx] != 0) ? 2'd3 : (m_bub[idx] != 0) ? 2'd1 : (m_rem[idx] > 0) ? 2'd2 : 2'd0;
    eo = '0;
    if (RST) begin
      eo = 7'b0000011;
      m_rem[idx] = 0; m_bub[idx] = 0; m_miss[idx] = 0;
      m_lu[idx] = 0; m_br[idx] = 0; m_dm[idx] = 0;
    end else if (!dcr) begin
      eo = 7'b1111100;
      m_miss[idx] = 1; m_bub[idx] = 0; m_dm[idx]++;
    end else begin
      m_miss[idx] = 0;
      if (bt) begin
        eo = 7'b0000011; m_rem[idx] = fc; m_bub[idx] = 0; m_br[idx]++;
      end else if (m_rem[idx] > 0) begin
        eo = 7'b0000010; m_rem[idx]--; m_bub[idx] = 0;
      end else if (hz && m_bub[idx] == 0) begin
        eo = 7'b1100001; m_bub[idx] = 1; m_lu[idx]++;
      end else if (!icr) begin
        eo = 7'b1000010; m_bub[idx] = 0;
      end else begin
        m_bub[idx] = 0;
      end
    end
  endtask

  initial begin
    logic [6:0] eo_a, eo_b;
    logic [1:0] es_a, es_b;

    // reset, then idle
    add(1, 0, 0, 0, 0, 0, 0, 3'd0, 0, 1, 1, 7'b0000011, 2'd0, 7'b0000011, 2'd0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 3'd0, 0, 1, 1, 7'b0000011, 2'd0, 7'b0000011, 2'd0, 1);
    add_idle(7'b0, 2'd0, 7'b0, 2'd0);
    // load-use on rs2 = rd = 5, held for the bubble cycle (masked), then x0 case
    add(0, 0, 5, 0, 1, 5, 1, 3'd3, 0, 1, 1, 7'b1100001, 2'd0, 7'b1100001, 2'd0, 1);
    add(0, 0, 5, 0, 1, 5, 1, 3'd3, 0, 1, 1, 7'b0000000, 2'd1, 7'b0000000, 2'd1, 1);
    add_idle(7'b0, 2'd0, 7'b0, 2'd0);
    add(0, 0, 0, 1, 1, 0, 1, 3'd3, 0, 1, 1, 7'b0000000, 2'd0, 7'b0000000, 2'd0, 1);
    // branch pulse
    add(0, 0, 0, 0, 0, 0, 0, 3'd0, 1, 1, 1, 7'b0000011, 2'd0, 7'b0000011, 2'd0, 1);
    add_idle(7'b0000010, 2'd2, 7'b0, 2'd0);
    add_idle(7'b0000010, 2'd2, 7'b0, 2'd0);
    add_idle(7'b0, 2'd0, 7'b0, 2'd0);
    // branch, one flush cycle, then a 4-cycle data miss, then resume
    add(0, 0, 0, 0, 0, 0, 0, 3'd0, 1, 1, 1, 7'b0000011, 2'd0, 7'b0000011, 2'd0, 1);
    add_idle(7'b0000010, 2'd2, 7'b0, 2'd0);
    add(0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 1, 0, 7'b1111100, 2'd2, 7'b1111100, 2'd0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 1, 0, 7'b1111100, 2'd3, 7'b1111100, 2'd3, 1);
    add(0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 1, 0, 7'b1111100, 2'd3, 7'b1111100, 2'd3, 1);
    add(0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 1, 0, 7'b1111100, 2'd3, 7'b1111100, 2'd3, 1);
    add_idle(7'b0000010, 2'd3, 7'b0, 2'd3);
    add_idle(7'b0, 2'd0, 7'b0, 2'd0);
    // I-miss coincident with branch, then I-miss alone
    add(0, 0, 0, 0, 0, 0, 0, 3'd0, 1, 0, 1, 7'b0000011, 2'd0, 7'b0000011, 2'd0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 1, 7'b0000010, 2'd2, 7'b1000010, 2'd0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 1, 7'b0000010, 2'd2, 7'b1000010, 2'd0, 1);
    add_idle(7'b0, 2'd0, 7'b0, 2'd0);
    // reset in the middle of a branch flush
    add(0, 0, 0, 0, 0, 0, 0, 3'd0, 1, 1, 1, 7'b0000011, 2'd0, 7'b0000011, 2'd0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 3'd0, 0, 1, 1, 7'b0000011, 2'd2, 7'b0000011, 2'd0, 1);
    add_idle(7'b0, 2'd0, 7'b0, 2'd0);

    foreach (tbl[i]) begin
      set_in(tbl[i].rst, tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2, tbl[i].rd,
             tbl[i].we, tbl[i].ld, tbl[i].bt, tbl[i].icr, tbl[i].dcr);
      @(negedge CLK);
      check($sformatf("vec%0d_out_a", i), 32'(out_a), 32'(tbl[i].ea));
      check($sformatf("vec%0d_out_b", i), 32'(out_b), 32'(tbl[i].eb));
      if (tbl[i].chk_st) begin
        check($sformatf("vec%0d_state_a", i), 32'(st_a), 32'(tbl[i].sa));
        check($sformatf("vec%0d_state_b", i), 32'(st_b), 32'(tbl[i].sb));
      end
      @(posedge CLK);
      #1;
    end

    // Both instances are in RUN with no pending flush and cleared counters here.
    for (int k = 0; k < 2; k++) begin
      m_rem[k] = 0; m_bub[k] = 0; m_miss[k] = 0; m_lu[k] = 0; m_br[k] = 0; m_dm[k] = 0;
    end

    for (int n = 0; n < 2000; n++) begin
      set_in($urandom_range(0, 99) < 2, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), $urandom_range(0, 9) < 8,
             3'($urandom_range(0, 7)), $urandom_range(0, 99) < 12,
             $urandom_range(0, 99) >= 20, $urandom_range(0, 99) >= 12);
      @(negedge CLK);
`ifdef HAZARD_PERF_COUNTERS_EN
      check($sformatf("rnd%0d_plu_a", n), plu_a, 32'(m_lu[0]));
      check($sformatf("rnd%0d_pbr_a", n), pbr_a, 32'(m_br[0]));
      check($sformatf("rnd%0d_pdm_a", n), pdm_a, 32'(m_dm[0]));
      check($sformatf("rnd%0d_plu_b", n), plu_b, 32'(m_lu[1]));
`endif
      model_step(0, 2, eo_a, es_a);
      model_step(1, 0, eo_b, es_b);
      check($sformatf("rnd%0d_out_a", n), 32'(out_a), 32'(eo_a));
      check($sformatf("rnd%0d_state_a", n), 32'(st_a), 32'(es_a));
      check($sformatf("rnd%0d_out_b", n), 32'(out_b), 32'(eo_b));
      check($sformatf("rnd%0d_state_b", n), 32'(st_b), 32'(es_b));
      @(posedge CLK);
      #1;
    end

`ifdef HAZARD_PERF_COUNTERS_EN
    // Two load-use bubbles, one branch, four data-miss cycles, then reset clears.
    set_in(1, 0, 0, 0, 0, 0, 0, 3'd0, 0, 1, 1); tick();
    set_in(0, 7, 0, 1, 0, 7, 1, 3'd2, 0, 1, 1); tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 1, 1); tick();
    set_in(0, 0, 9, 0, 1, 9, 1, 3'd1, 0, 1, 1); tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 1, 1); tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 3'd0, 1, 1, 1); tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 1, 1); tick(); tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 1, 0); tick(); tick(); tick(); tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 1, 1);
    @(negedge CLK);
    check("perf_load_use", plu_a, 32'd2);
    check("perf_branch", pbr_a, 32'd1);
    check("perf_dmiss", pdm_a, 32'd4);
    @(posedge CLK); #1;
    set_in(1, 0, 0, 0, 0, 0, 0, 3'd0, 0, 1, 1); tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 1, 1);
    @(negedge CLK);
    check("perf_load_use_rst", plu_a, 32'd0);
    check("perf_branch_rst", pbr_a, 32'd0);
    check("perf_dmiss_rst", pdm_a, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
